// File: rtl/lti_stim_pkg.sv
// Shared definitions for the LTI stimulus sources.
// Contains the waveform mode encodings, the FSM states and a saturating adder.
package lti_stim_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_STEP   = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_RAMP   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } src_state_e;

    // Wide enough to hold the exact sum of two sign-extended samples of any practical width.
    localparam int SAT_W = 64;
    typedef logic signed [SAT_W-1:0] sat_word_t;

    // Adds two sign-extended operands and clamps the result to the signed range of 'width' bits.
    function automatic sat_word_t sat_add(input sat_word_t a, input sat_word_t b, input int width);
        sat_word_t sum;
        sat_word_t max_v;
        sat_word_t min_v;
        sum   = a + b;
        max_v = (sat_word_t'(1) <<< (width - 1)) - sat_word_t'(1);
        min_v = -max_v - sat_word_t'(1);
        if (sum > max_v) begin
            return max_v;
        end
        if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/ce_strobe_divider.sv
// Clock-enable divider: while run=1, counts 0..DIV-1 and flags ce on the wrap cycle.
// Held at zero while run=0, so the first ce after run rises is exactly DIV clocks later.
module ce_strobe_divider #(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic ce
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ce = run && (cnt == LAST);

endmodule

// File: rtl/lti_stimulus_source.sv
// Built-in excitation source: one-cycle ce_out every DIV clocks with a registered signed sample.
// Optional macro LTI_SRC_RAMP_SAT_EN makes the ramp saturate (sticky) instead of wrapping.
module lti_stimulus_source
    import lti_stim_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIV        = 5,
    parameter int PER_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] amplitude,
    input  logic [PER_WIDTH-1:0]  half_period,
    output logic                  ce_out,
    output logic [DATA_WIDTH-1:0] sig_out_1,
    output logic                  running
);

    // Two extra bits so the full square period 2*H and its increment never overflow.
    localparam int KW = PER_WIDTH + 2;

    src_state_e                   state;
    mode_e                        last_mode;
    logic [KW-1:0]                k_cnt;
    logic signed [DATA_WIDTH-1:0] ramp_acc;
`ifdef LTI_SRC_RAMP_SAT_EN
    logic                         ramp_sat;
    logic                         sat_base;
    logic                         sat_next;
    sat_word_t                    ramp_sum;
`endif

    logic                         div_run;
    logic                         tick;
    mode_e                        mode_sel;
    logic signed [DATA_WIDTH-1:0] amp_s;
    logic signed [DATA_WIDTH-1:0] amp_neg;
    logic                         restart;
    logic [KW-1:0]                k_base;
    logic [KW-1:0]                k_inc;
    logic [KW-1:0]                h_len;
    logic [KW-1:0]                k_next;
    logic signed [DATA_WIDTH-1:0] acc_base;
    logic signed [DATA_WIDTH-1:0] acc_next;
    logic signed [DATA_WIDTH-1:0] sample_next;

    assign div_run  = (state == ST_RUN);
    assign mode_sel = mode_e'(mode);
    assign amp_s    = amplitude;
    // Negating the most negative amplitude would overflow; clamp it to +max instead.
    assign amp_neg  = DATA_WIDTH'(sat_add('0, -sat_word_t'(amp_s), DATA_WIDTH));

    ce_strobe_divider #(
        .DIV (DIV)
    ) u_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (div_run),
        .ce    (tick)
    );

    // NOTE: every signal written here gets a default first, so no latches can be inferred.
    always_comb begin
        restart     = (mode_sel != last_mode);
        k_base      = restart ? '0 : k_cnt;
        acc_base    = restart ? '0 : ramp_acc;
        h_len       = (half_period == '0) ? KW'(1) : KW'(half_period);
        k_inc       = k_base + 1'b1;
        k_next      = k_base;
        acc_next    = acc_base;
        sample_next = '0;
`ifdef LTI_SRC_RAMP_SAT_EN
        sat_base    = restart ? 1'b0 : ramp_sat;
        sat_next    = sat_base;
        ramp_sum    = '0;
`endif
        unique case (mode_sel)
            MODE_ZERO: begin
                sample_next = '0;
            end
            MODE_STEP: begin
                sample_next = amp_s;
            end
            MODE_SQUARE: begin
                sample_next = (k_base < h_len) ? amp_s : amp_neg;
                k_next      = (k_inc >= (h_len << 1)) ? '0 : k_inc;
            end
            MODE_RAMP: begin
`ifdef LTI_SRC_RAMP_SAT_EN
                ramp_sum = sat_word_t'(acc_base) + sat_word_t'(amp_s);
                if (!sat_base) begin
                    acc_next = DATA_WIDTH'(sat_add(sat_word_t'(acc_base), sat_word_t'(amp_s), DATA_WIDTH));
                    sat_next = (sat_word_t'(acc_next) != ramp_sum);
                end
`else
                acc_next = acc_base + amp_s;
`endif
                sample_next = acc_next;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            ce_out    <= 1'b0;
            sig_out_1 <= '0;
            k_cnt     <= '0;
            ramp_acc  <= '0;
            last_mode <= MODE_ZERO;
`ifdef LTI_SRC_RAMP_SAT_EN
            ramp_sat  <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    ce_out <= 1'b0;
                    if (enable) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Leave at once: a strobe due on this edge is dropped, sample is held.
                        state    <= ST_IDLE;
                        running  <= 1'b0;
                        ce_out   <= 1'b0;
                        k_cnt    <= '0;
                        ramp_acc <= '0;
`ifdef LTI_SRC_RAMP_SAT_EN
                        ramp_sat <= 1'b0;
`endif
                    end else begin
                        ce_out <= tick;
                        if (tick) begin
                            sig_out_1 <= sample_next;
                            k_cnt     <= k_next;
                            ramp_acc  <= acc_next;
                            last_mode <= mode_sel;
`ifdef LTI_SRC_RAMP_SAT_EN
                            ramp_sat  <= sat_next;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lti_stimulus_source.sv
// Self-checking bench for lti_stimulus_source: table of waveform vectors plus hand-written
// reset, enable-drop and mid-period mode-change sequences, scored against a strobe queue.
module tb_lti_stimulus_source;
    import lti_stim_pkg::*;

    localparam int DW  = 16;
    localparam int DIV = 5;
    localparam int PW  = 16;
    localparam int NV  = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [DW-1:0] amplitude;
    logic [PW-1:0] half_period;
    logic          ce_out;
    logic [DW-1:0] sig_out_1;
    logic          running;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [1:0]        mode;
        logic [15:0]       amp;
        logic [15:0]       hp;
        int                n;
        logic [7:0][15:0]  exp;
    } vec_t;

    vec_t vecs[NV];

    always #5 clk = ~clk;

    lti_stimulus_source #(
        .DATA_WIDTH (DW),
        .DIV        (DIV),
        .PER_WIDTH  (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .amplitude   (amplitude),
        .half_period (half_period),
        .ce_out      (ce_out),
        .sig_out_1   (sig_out_1),
        .running     (running)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the next strobe; returns the number of clocks it took.
    task automatic wait_strobe(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (ce_out !== 1'b1 && cycles < 4 * DIV);
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [15:0] a, input logic [15:0] h,
                                input int n,
                                input logic [15:0] e0 = '0, input logic [15:0] e1 = '0,
                                input logic [15:0] e2 = '0, input logic [15:0] e3 = '0,
                                input logic [15:0] e4 = '0, input logic [15:0] e5 = '0,
                                input logic [15:0] e6 = '0, input logic [15:0] e7 = '0);
        vec_t v;
        v.mode   = m;
        v.amp    = a;
        v.hp     = h;
        v.n      = n;
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        v.exp[4] = e4;
        v.exp[5] = e5;
        v.exp[6] = e6;
        v.exp[7] = e7;
        return v;
    endfunction

    // Scoreboard: every strobe seen on the falling edge must match the oldest expected sample.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (ce_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got strobe with sample %0h, required no strobe", sig_out_1);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_sample", 32'(sig_out_1), 32'(e));
                end
            end
        end
    end

    initial begin
        int cyc;
        int seen;

        vecs[0] = mk(MODE_STEP,   16'h4000, 16'd0, 3, 16'h4000, 16'h4000, 16'h4000);
        vecs[1] = mk(MODE_SQUARE, 16'h0064, 16'd3, 7, 16'h0064, 16'h0064, 16'h0064,
                     16'hFF9C, 16'hFF9C, 16'hFF9C, 16'h0064);
        vecs[2] = mk(MODE_SQUARE, 16'h0064, 16'd0, 4, 16'h0064, 16'hFF9C, 16'h0064, 16'hFF9C);
        vecs[3] = mk(MODE_SQUARE, 16'h8000, 16'd1, 3, 16'h8000, 16'h7FFF, 16'h8000);
`ifdef LTI_SRC_RAMP_SAT_EN
        vecs[4] = mk(MODE_RAMP,   16'h3000, 16'd0, 4, 16'h3000, 16'h6000, 16'h7FFF, 16'h7FFF);
        vecs[7] = mk(MODE_RAMP,   16'h8000, 16'd0, 3, 16'h8000, 16'h8000, 16'h8000);
`else
        vecs[4] = mk(MODE_RAMP,   16'h3000, 16'd0, 4, 16'h3000, 16'h6000, 16'h9000, 16'hC000);
        vecs[7] = mk(MODE_RAMP,   16'h8000, 16'd0, 3, 16'h8000, 16'h0000, 16'h8000);
`endif
        vecs[5] = mk(MODE_RAMP,   16'hFFFF, 16'd0, 3, 16'hFFFF, 16'hFFFE, 16'hFFFD);
        vecs[6] = mk(MODE_ZERO,   16'h1234, 16'd0, 2, 16'h0000, 16'h0000);
        vecs[8] = mk(MODE_SQUARE, 16'hFF38, 16'd2, 5, 16'hFF38, 16'hFF38, 16'h00C8,
                     16'h00C8, 16'hFF38);

        // Reset held with enable high: outputs stay quiet.
        rst_n       = 1'b0;
        enable      = 1'b1;
        mode        = MODE_STEP;
        amplitude   = 16'h4000;
        half_period = '0;
        tick();
        tick();
        tick();
        check("reset_ce_out", 32'(ce_out), 32'd0);
        check("reset_sig_out", 32'(sig_out_1), 32'd0);
        check("reset_running", 32'(running), 32'd0);

        // Release between edges; the next edge samples enable.
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'h4000);
        rst_n = 1'b1;
        tick();
        check("running_after_enable", 32'(running), 32'd1);
        check("no_ce_at_enable", 32'(ce_out), 32'd0);
        wait_strobe(cyc);
        check("first_strobe_latency", 32'(cyc), 32'(DIV));
        wait_strobe(cyc);
        check("step_period", 32'(cyc), 32'(DIV));
        tick();
        check("strobe_width", 32'(ce_out), 32'd0);
        check("step_hold", 32'(sig_out_1), 32'h4000);

        // Enable dropped mid-period, then re-enabled: divider and k restart.
        enable = 1'b0;
        tick();
        tick();
        mode        = MODE_SQUARE;
        amplitude   = 16'h0032;
        half_period = 16'd2;
        exp_q.push_back(16'h0032);
        exp_q.push_back(16'h0032);
        exp_q.push_back(16'hFFCE);
        enable = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            wait_strobe(cyc);
            check("square_pre_drop_period", 32'(cyc), 32'(DIV));
        end
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("drop_ce_out", 32'(ce_out), 32'd0);
        check("drop_sig_held", 32'(sig_out_1), 32'hFFCE);
        check("drop_running", 32'(running), 32'd0);
        seen = 0;
        for (int j = 0; j < 2 * DIV; j++) begin
            tick();
            if (ce_out === 1'b1) seen++;
        end
        check("idle_no_strobe", 32'(seen), 32'd0);
        check("idle_sig_held", 32'(sig_out_1), 32'hFFCE);
        exp_q.push_back(16'h0032);
        exp_q.push_back(16'h0032);
        exp_q.push_back(16'hFFCE);
        enable = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            wait_strobe(cyc);
            check("reenable_period", 32'(cyc), 32'(DIV));
        end

        // Mode 1->3 mid-period: takes effect at the next strobe with a fresh ramp.
        enable = 1'b0;
        tick();
        tick();
        mode      = MODE_STEP;
        amplitude = 16'h0100;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0100);
        enable = 1'b1;
        tick();
        wait_strobe(cyc);
        wait_strobe(cyc);
        check("step_before_change_period", 32'(cyc), 32'(DIV));
        tick();
        tick();
        mode = MODE_RAMP;
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0300);
        tick();
        check("mode_change_ce_low", 32'(ce_out), 32'd0);
        check("mode_change_sig_held", 32'(sig_out_1), 32'h0100);
        wait_strobe(cyc);
        check("mode_change_strobe_timing", 32'(cyc), 32'(DIV - 3));
        wait_strobe(cyc);
        check("ramp_after_change_period", 32'(cyc), 32'(DIV));
        wait_strobe(cyc);
        check("ramp_after_change_period", 32'(cyc), 32'(DIV));
        enable = 1'b0;
        tick();
        tick();
        check("hand_seq_queue_drained", 32'(exp_q.size()), 32'd0);

        // Table-driven waveform vectors, each started from IDLE.
        for (int i = 0; i < NV; i++) begin
            enable = 1'b0;
            tick();
            tick();
            mode        = vecs[i].mode;
            amplitude   = vecs[i].amp;
            half_period = vecs[i].hp;
            for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].exp[j]);
            enable = 1'b1;
            tick();
            check("vec_running", 32'(running), 32'd1);
            for (int j = 0; j < vecs[i].n; j++) begin
                wait_strobe(cyc);
                check("vec_period", 32'(cyc), 32'(DIV));
            end
            enable = 1'b0;
            tick();
            check("vec_idle_ce_out", 32'(ce_out), 32'd0);
            check("vec_idle_sig_held", 32'(sig_out_1), 32'(vecs[i].exp[vecs[i].n - 1]));
            check("vec_idle_running", 32'(running), 32'd0);
            check("vec_queue_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
